line_buf_ctrl: RTL and testbench

LINE_BUF_CTRL -- requirements
Module: line_buf_ctrl

---
 rtl/line_buf_ctrl_pkg.sv | 10 +
 rtl/line_buf_port_mux.sv | 71 +++++++
 rtl/line_buf_ctrl.sv | 166 ++++++++++++++++
 tb/tb_line_buf_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/line_buf_ctrl_pkg.sv
// Shared video package: line-buffer controller state encoding.
package line_buf_ctrl_pkg;

  // CLEAR sweeps both banks to the transparent value; RUN serves draw/display traffic.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } lbc_state_e;

endpackage

// File: rtl/line_buf_port_mux.sv
// Maps logical sweep / clear-write / display-read / draw-write requests onto
// physical RAM ports a and b. Priority per bank: sweep, clear-write, read, draw.
module line_buf_port_mux #(
  parameter int PIX_AW = 8,
  parameter int DW     = 8
) (
  input  logic              bank_sel,
  input  logic              sweep_en,
  input  logic [PIX_AW-1:0] sweep_addr,
  input  logic [DW-1:0]     sweep_data,
  input  logic              clr_en,
  input  logic              clr_bank,
  input  logic [PIX_AW-1:0] clr_addr,
  input  logic [DW-1:0]     clr_data,
  input  logic              rd_req,
  input  logic [PIX_AW-1:0] rd_addr,
  input  logic              wr_req,
  input  logic [PIX_AW-1:0] wr_addr,
  input  logic [DW-1:0]     wr_data,
  output logic              a_act,
  output logic              a_rd,
  output logic [PIX_AW-1:0] a_addr,
  output logic [DW-1:0]     a_data,
  output logic              b_act,
  output logic              b_rd,
  output logic [PIX_AW-1:0] b_addr,
  output logic [DW-1:0]     b_data
);

  logic [1:0]        act;
  logic [1:0]        rd;
  logic [PIX_AW-1:0] addr [2];
  logic [DW-1:0]     data [2];

  // Per-bank arbitration; index 0 is bank a, index 1 is bank b.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      act[k]  = 1'b0;
      rd[k]   = 1'b0;
      addr[k] = '0;
      data[k] = '0;
      if (sweep_en) begin
        act[k]  = 1'b1;
        addr[k] = sweep_addr;
        data[k] = sweep_data;
      end else if (clr_en && (clr_bank == 1'(k))) begin
        act[k]  = 1'b1;
        addr[k] = clr_addr;
        data[k] = clr_data;
      end else if (rd_req && (bank_sel == 1'(k))) begin
        act[k]  = 1'b1;
        rd[k]   = 1'b1;
        addr[k] = rd_addr;
      end else if (wr_req && (bank_sel != 1'(k))) begin
        act[k]  = 1'b1;
        addr[k] = wr_addr;
        data[k] = wr_data;
      end
    end
  end

  assign a_act  = act[0];
  assign a_rd   = rd[0];
  assign a_addr = addr[0];
  assign a_data = data[0];
  assign b_act  = act[1];
  assign b_rd   = rd[1];
  assign b_addr = addr[1];
  assign b_data = data[1];

endmodule

// File: rtl/line_buf_ctrl.sv
// Double-banked sprite line buffer controller. One bank is displayed (and
// cleared behind the display read) while the sprite engine draws the other.
// Handshake: a write is accepted in any cycle where wr_valid && wr_ready; the
// master holds wr_x/wr_pix until accepted. rd_en is a strobe with no back-pressure.
module line_buf_ctrl
  import line_buf_ctrl_pkg::*;
#(
  parameter int             PIX_AW    = 8,
  parameter int             DW        = 8,
  parameter logic [DW-1:0]  CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hblank_start,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [PIX_AW-1:0] wr_x,
  input  logic [DW-1:0]     wr_pix,
  input  logic              rd_en,
  input  logic [PIX_AW-1:0] rd_x,
  output logic [DW-1:0]     rd_pix,
  output logic              rd_pix_valid,
  output logic [PIX_AW-1:0] a_addr,
  output logic [DW-1:0]     a_data,
  output logic              a_cen,
  output logic              a_oen,
  output logic              a_wen,
  input  logic [DW-1:0]     a_q,
  output logic [PIX_AW-1:0] b_addr,
  output logic [DW-1:0]     b_data,
  output logic              b_cen,
  output logic              b_oen,
  output logic              b_wen,
  input  logic [DW-1:0]     b_q,
  output logic              dbg_state
);

  lbc_state_e        state_q, state_d;
  logic [PIX_AW-1:0] cnt_q, cnt_d;
  logic              bank_sel_q, bank_sel_d;
  logic              pend_q, pend_d;
  logic              pend_ram_q, pend_ram_d;
  logic              pend_bank_q, pend_bank_d;
  logic [PIX_AW-1:0] pend_x_q, pend_x_d;
  logic [DW-1:0]     rd_pix_q, rd_pix_d;
  logic              rd_valid_q, rd_valid_d;
  logic [PIX_AW-1:0] a_addr_q, a_addr_d, b_addr_q, b_addr_d;
  logic [DW-1:0]     a_data_q, a_data_d, b_data_q, b_data_d;

  logic              run, sweep_en, clr_en, rd_req, wr_req, conflict;
  logic              m_a_act, m_a_rd, m_b_act, m_b_rd;
  logic [PIX_AW-1:0] m_a_addr, m_b_addr;
  logic [DW-1:0]     m_a_data, m_b_data;

  assign run      = !reset && (state_q == ST_RUN);
  assign sweep_en = !reset && (state_q == ST_CLEAR);
  // The trailing clear-write owns its bank; if that is now the draw bank, stall writes.
  assign clr_en   = !reset && pend_q && pend_ram_q;
  assign conflict = clr_en && (pend_bank_q != bank_sel_q);
  assign wr_ready = run && !conflict;
  // Transparent pixels are consumed without touching the RAM.
  assign wr_req   = wr_valid && wr_ready && (wr_pix != CLEAR_VAL);
  assign rd_req   = run && rd_en;

  line_buf_port_mux #(.PIX_AW(PIX_AW), .DW(DW)) u_mux (
    .bank_sel   (bank_sel_q),
    .sweep_en   (sweep_en),
    .sweep_addr (cnt_q),
    .sweep_data (CLEAR_VAL),
    .clr_en     (clr_en),
    .clr_bank   (pend_bank_q),
    .clr_addr   (pend_x_q),
    .clr_data   (CLEAR_VAL),
    .rd_req     (rd_req),
    .rd_addr    (rd_x),
    .wr_req     (wr_req),
    .wr_addr    (wr_x),
    .wr_data    (wr_pix),
    .a_act      (m_a_act),
    .a_rd       (m_a_rd),
    .a_addr     (m_a_addr),
    .a_data     (m_a_data),
    .b_act      (m_b_act),
    .b_rd       (m_b_rd),
    .b_addr     (m_b_addr),
    .b_data     (m_b_data)
  );

  // Idle ports keep the last address/data driven on them.
  assign a_cen  = !m_a_act;
  assign a_oen  = !(m_a_act && m_a_rd);
  assign a_wen  = !(m_a_act && !m_a_rd);
  assign a_addr = m_a_act ? m_a_addr : a_addr_q;
  assign a_data = m_a_act ? m_a_data : a_data_q;
  assign b_cen  = !m_b_act;
  assign b_oen  = !(m_b_act && m_b_rd);
  assign b_wen  = !(m_b_act && !m_b_rd);
  assign b_addr = m_b_act ? m_b_addr : b_addr_q;
  assign b_data = m_b_act ? m_b_data : b_data_q;

  assign rd_pix       = rd_pix_q;
  assign rd_pix_valid = rd_valid_q;
  assign dbg_state    = state_q;

  // Next-state: sweep counter, bank swap, read pipeline and port hold values.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bank_sel_d  = hblank_start ? !bank_sel_q : bank_sel_q;
    pend_d      = rd_en;
    pend_ram_d  = rd_en && (state_q == ST_RUN);
    pend_bank_d = rd_en ? bank_sel_q : pend_bank_q;
    pend_x_d    = rd_en ? rd_x : pend_x_q;
    rd_valid_d  = pend_q;
    rd_pix_d    = rd_pix_q;
    if (pend_q) begin
      if (pend_ram_q) rd_pix_d = pend_bank_q ? b_q : a_q;
      else            rd_pix_d = CLEAR_VAL;
    end
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
    a_addr_d = a_addr;
    a_data_d = a_data;
    b_addr_d = b_addr;
    b_data_d = b_data;
  end

  // State registers; reset restarts the sweep and cancels any in-flight read.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_CLEAR;
      cnt_q       <= '0;
      bank_sel_q  <= 1'b0;
      pend_q      <= 1'b0;
      pend_ram_q  <= 1'b0;
      pend_bank_q <= 1'b0;
      pend_x_q    <= '0;
      rd_pix_q    <= CLEAR_VAL;
      rd_valid_q  <= 1'b0;
      a_addr_q    <= '0;
      a_data_q    <= '0;
      b_addr_q    <= '0;
      b_data_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bank_sel_q  <= bank_sel_d;
      pend_q      <= pend_d;
      pend_ram_q  <= pend_ram_d;
      pend_bank_q <= pend_bank_d;
      pend_x_q    <= pend_x_d;
      rd_pix_q    <= rd_pix_d;
      rd_valid_q  <= rd_valid_d;
      a_addr_q    <= a_addr_d;
      a_data_q    <= a_data_d;
      b_addr_q    <= b_addr_d;
      b_data_q    <= b_data_d;
    end
  end

endmodule

// File: tb/tb_line_buf_ctrl.sv
// Directed bench for line_buf_ctrl with behavioural models of both bank RAMs.
module tb_line_buf_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       hblank_start = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] wr_x = '0;
  logic [7:0] wr_pix = '0;
  logic       rd_en = 1'b0;
  logic [7:0] rd_x = '0;
  logic [7:0] rd_pix;
  logic       rd_pix_valid;
  logic [7:0] a_addr, a_data, a_q;
  logic       a_cen, a_oen, a_wen;
  logic [7:0] b_addr, b_data, b_q;
  logic       b_cen, b_oen, b_wen;
  logic       dbg_state;

  int total = 0;
  int bad = 0;

  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];

  line_buf_ctrl dut (
    .clk(clk), .reset(reset), .hblank_start(hblank_start),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_pix(wr_pix),
    .rd_en(rd_en), .rd_x(rd_x), .rd_pix(rd_pix), .rd_pix_valid(rd_pix_valid),
    .a_addr(a_addr), .a_data(a_data), .a_cen(a_cen), .a_oen(a_oen), .a_wen(a_wen), .a_q(a_q),
    .b_addr(b_addr), .b_data(b_data), .b_cen(b_cen), .b_oen(b_oen), .b_wen(b_wen), .b_q(b_q),
    .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Bank RAM models: synchronous write, registered read data.
  always @(posedge clk) begin
    if (!a_cen && !a_wen) mem_a[a_addr] <= a_data;
    if (!a_cen && !a_oen) a_q <= mem_a[a_addr];
    if (!b_cen && !b_wen) mem_b[b_addr] <= b_data;
    if (!b_cen && !b_oen) b_q <= mem_b[b_addr];
  end

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL reset_wr_ready got=%0b exp=0", wr_ready); end
    total++; if (rd_pix_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", rd_pix_valid); end
    total++; if (rd_pix !== 8'h00) begin bad++; $display("FAIL reset_rd_pix got=%0h exp=00", rd_pix); end
    total++; if ({a_cen, a_oen, a_wen, b_cen, b_oen, b_wen} !== 6'b111111) begin bad++;
      $display("FAIL reset_ports got=%b exp=111111", {a_cen, a_oen, a_wen, b_cen, b_oen, b_wen}); end
    total++; if (dbg_state !== 1'b0) begin bad++; $display("FAIL reset_state got=%0b exp=0", dbg_state); end
  endtask

  // Full sweep; an rd_en and an hblank pulse are injected mid-sweep.
  task automatic test_clear_sweep();
    logic [37:0] got, exp;
    reset = 1'b0;
    for (int i = 0; i < 256; i++) begin
      rd_en = (i == 10);
      rd_x = 8'd3;
      hblank_start = (i == 20);
      #1;
      got = {a_cen, a_wen, a_oen, a_addr, a_data, b_cen, b_wen, b_oen, b_addr, b_data, wr_ready};
      exp = {1'b0, 1'b0, 1'b1, 8'(i), 8'h00, 1'b0, 1'b0, 1'b1, 8'(i), 8'h00, 1'b0};
      total++; if (got !== exp) begin bad++; $display("FAIL sweep_%0d got=%h exp=%h", i, got, exp); end
      if (i == 11) begin
        total++; if (rd_pix_valid !== 1'b0) begin bad++; $display("FAIL clr_rd_early got=%0b exp=0", rd_pix_valid); end
      end
      if (i == 12) begin
        total++; if ({rd_pix_valid, rd_pix} !== 9'h100) begin bad++;
          $display("FAIL clr_rd_pulse got=%h exp=100", {rd_pix_valid, rd_pix}); end
      end
      if (i == 13) begin
        total++; if (rd_pix_valid !== 1'b0) begin bad++; $display("FAIL clr_rd_late got=%0b exp=0", rd_pix_valid); end
      end
      @(negedge clk);
    end
    rd_en = 1'b0;
    hblank_start = 1'b0;
    #1;
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL run_wr_ready got=%0b exp=1", wr_ready); end
    total++; if (dbg_state !== 1'b1) begin bad++; $display("FAIL run_state got=%0b exp=1", dbg_state); end
    total++; if ({a_cen, b_cen} !== 2'b11) begin bad++; $display("FAIL run_idle got=%b exp=11", {a_cen, b_cen}); end
  endtask

  // bank_sel is 1 after the hblank during CLEAR, so draws land in bank a.
  task automatic test_draw_a();
    wr_valid = 1'b1; wr_x = 8'd7; wr_pix = 8'h11;
    #1;
    total++; if ({a_cen, a_wen, a_oen, a_addr, a_data, b_cen} !== {3'b001, 8'd7, 8'h11, 1'b1}) begin bad++;
      $display("FAIL draw_a got=%h exp=%h", {a_cen, a_wen, a_oen, a_addr, a_data, b_cen}, {3'b001, 8'd7, 8'h11, 1'b1}); end
    @(negedge clk);
    wr_valid = 1'b0;
    #1;
    total++; if ({a_cen, a_wen, a_oen, a_addr, a_data} !== {3'b111, 8'd7, 8'h11}) begin bad++;
      $display("FAIL idle_hold got=%h exp=%h", {a_cen, a_wen, a_oen, a_addr, a_data}, {3'b111, 8'd7, 8'h11}); end
    total++; if (mem_a[7] !== 8'h11) begin bad++; $display("FAIL draw_a_mem got=%0h exp=11", mem_a[7]); end
    hblank_start = 1'b1;
    @(negedge clk);
    hblank_start = 1'b0;
  endtask

  // bank_sel=0: draw to b, swap, read back and check the trailing clear.
  task automatic test_read_clear();
    wr_valid = 1'b1; wr_x = 8'd5; wr_pix = 8'h3C;
    #1;
    total++; if ({b_cen, b_wen, b_addr, b_data, a_cen} !== {2'b00, 8'd5, 8'h3C, 1'b1}) begin bad++;
      $display("FAIL draw_b got=%h exp=%h", {b_cen, b_wen, b_addr, b_data, a_cen}, {2'b00, 8'd5, 8'h3C, 1'b1}); end
    @(negedge clk);
    wr_valid = 1'b0; hblank_start = 1'b1;
    @(negedge clk);
    hblank_start = 1'b0; rd_en = 1'b1; rd_x = 8'd5;
    #1;
    total++; if ({b_cen, b_oen, b_wen, b_addr, a_cen} !== {3'b001, 8'd5, 1'b1}) begin bad++;
      $display("FAIL rd_b got=%h exp=%h", {b_cen, b_oen, b_wen, b_addr, a_cen}, {3'b001, 8'd5, 1'b1}); end
    @(negedge clk);
    rd_en = 1'b0;
    #1;
    total++; if ({b_cen, b_oen, b_wen, b_addr, b_data} !== {3'b010, 8'd5, 8'h00}) begin bad++;
      $display("FAIL clr_b got=%h exp=%h", {b_cen, b_oen, b_wen, b_addr, b_data}, {3'b010, 8'd5, 8'h00}); end
    total++; if ({wr_ready, rd_pix_valid} !== 2'b10) begin bad++;
      $display("FAIL n1_flags got=%b exp=10", {wr_ready, rd_pix_valid}); end
    @(negedge clk); #1;
    total++; if ({rd_pix_valid, rd_pix} !== 9'h13C) begin bad++;
      $display("FAIL rd_pix_b got=%h exp=13c", {rd_pix_valid, rd_pix}); end
    @(negedge clk); #1;
    total++; if (rd_pix_valid !== 1'b0) begin bad++; $display("FAIL rd_pulse_end got=%0b exp=0", rd_pix_valid); end
    total++; if (mem_b[5] !== 8'h00) begin bad++; $display("FAIL clr_b_mem got=%0h exp=00", mem_b[5]); end
  endtask

  // Transparent pixel: accepted but no RAM access.
  task automatic test_clear_pix();
    wr_valid = 1'b1; wr_x = 8'd9; wr_pix = 8'h00;
    #1;
    total++; if ({wr_ready, a_cen, a_wen, b_cen, b_wen} !== 5'b11111) begin bad++;
      $display("FAIL clear_pix got=%b exp=11111", {wr_ready, a_cen, a_wen, b_cen, b_wen}); end
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  // Read + hblank together, then the clear-write collides with the new draw bank.
  task automatic test_swap_conflict();
    wr_valid = 1'b1; wr_x = 8'd20; wr_pix = 8'h77;
    @(negedge clk);
    wr_valid = 1'b0; hblank_start = 1'b1;
    @(negedge clk);
    rd_en = 1'b1; rd_x = 8'd20; hblank_start = 1'b1;
    wr_valid = 1'b1; wr_x = 8'd40; wr_pix = 8'h55;
    #1;
    total++; if ({a_cen, a_oen, a_addr} !== {2'b00, 8'd20}) begin bad++;
      $display("FAIL swap_rd got=%h exp=%h", {a_cen, a_oen, a_addr}, {2'b00, 8'd20}); end
    total++; if ({b_cen, b_wen, b_addr, b_data} !== {2'b00, 8'd40, 8'h55}) begin bad++;
      $display("FAIL swap_wr got=%h exp=%h", {b_cen, b_wen, b_addr, b_data}, {2'b00, 8'd40, 8'h55}); end
    @(negedge clk);
    rd_en = 1'b0; hblank_start = 1'b0; wr_x = 8'd41; wr_pix = 8'h66;
    #1;
    total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL conflict_ready got=%0b exp=0", wr_ready); end
    total++; if ({a_cen, a_wen, a_addr, a_data, b_cen} !== {2'b00, 8'd20, 8'h00, 1'b1}) begin bad++;
      $display("FAIL conflict_clr got=%h exp=%h", {a_cen, a_wen, a_addr, a_data, b_cen}, {2'b00, 8'd20, 8'h00, 1'b1}); end
    @(negedge clk); #1;
    total++; if ({wr_ready, a_cen, a_wen, a_addr, a_data} !== {3'b100, 8'd41, 8'h66}) begin bad++;
      $display("FAIL retry_wr got=%h exp=%h", {wr_ready, a_cen, a_wen, a_addr, a_data}, {3'b100, 8'd41, 8'h66}); end
    total++; if ({rd_pix_valid, rd_pix} !== 9'h177) begin bad++;
      $display("FAIL swap_rd_pix got=%h exp=177", {rd_pix_valid, rd_pix}); end
    @(negedge clk);
    wr_valid = 1'b0;
    #1;
    total++; if ({mem_a[20], mem_a[41], mem_b[40]} !== 24'h006655) begin bad++;
      $display("FAIL swap_mem got=%h exp=006655", {mem_a[20], mem_a[41], mem_b[40]}); end
  endtask

  // Reset lands on cycle N+1 of a read: no pulse, sweep restarts at 0.
  task automatic test_reset_midpipe();
    rd_en = 1'b1; rd_x = 8'd3;
    @(negedge clk);
    rd_en = 1'b0; reset = 1'b1;
    #1;
    total++; if ({a_cen, b_cen, wr_ready} !== 3'b110) begin bad++;
      $display("FAIL rst_mid_ports got=%b exp=110", {a_cen, b_cen, wr_ready}); end
    @(negedge clk); #1;
    total++; if ({rd_pix_valid, rd_pix} !== 9'h000) begin bad++;
      $display("FAIL rst_mid_out got=%h exp=000", {rd_pix_valid, rd_pix}); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if ({rd_pix_valid, dbg_state, wr_ready, a_cen, a_addr, b_cen, b_addr} !== {4'b0000, 8'd0, 1'b0, 8'd0}) begin bad++;
      $display("FAIL restart0 got=%h exp=%h", {rd_pix_valid, dbg_state, wr_ready, a_cen, a_addr, b_cen, b_addr},
               {4'b0000, 8'd0, 1'b0, 8'd0}); end
    @(negedge clk); #1;
    total++; if ({rd_pix_valid, a_cen, a_addr} !== {2'b00, 8'd1}) begin bad++;
      $display("FAIL restart1 got=%h exp=%h", {rd_pix_valid, a_cen, a_addr}, {2'b00, 8'd1}); end
  endtask

  initial begin
    test_reset();
    test_clear_sweep();
    test_draw_a();
    test_read_clear();
    test_clear_pix();
    test_swap_conflict();
    test_reset_midpipe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
